// File: rtl/fir_pkg.sv
// Shared constants, widths, FSM encoding and the folded coefficient table
// for the 32-tap symmetric FIR MAC scheduler.
package fir_pkg;

  localparam int NUM_TAPS   = 32;
  localparam int NUM_UNIQUE = 16;
  localparam int ADDR_W     = 5;
  localparam int K_W        = 4;
  localparam int SAMPLE_W   = 16;
  localparam int COEF_W     = 16;
  localparam int PAIR_W     = SAMPLE_W + 1;
  localparam int PROD_W     = PAIR_W + COEF_W;
  localparam int ACC_W      = PROD_W + 4;
  localparam int FRAC_W     = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_t;

  // Unique half of the symmetric Q15 impulse response, index k = tap k = tap 31-k.
  function automatic logic signed [COEF_W-1:0] coeff_at(input logic [K_W-1:0] k);
    logic signed [COEF_W-1:0] c;
    case (k)
      4'd0:    c = 16'sd1;
      4'd1:    c = -16'sd3;
      4'd2:    c = 16'sd12;
      4'd3:    c = -16'sd28;
      4'd4:    c = 16'sd40;
      4'd5:    c = -16'sd13;
      4'd6:    c = -16'sd98;
      4'd7:    c = 16'sd279;
      4'd8:    c = -16'sd399;
      4'd9:    c = 16'sd213;
      4'd10:   c = 16'sd462;
      4'd11:   c = -16'sd1474;
      4'd12:   c = 16'sd2148;
      4'd13:   c = -16'sd1348;
      4'd14:   c = -16'sd2619;
      default: c = 16'sd19210;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// 32x16 circular sample store: one write port, two combinational read ports,
// and a single-cycle clear of every entry.
module fir_delay_ram
  import fir_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clear,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic signed [SAMPLE_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]          i_rd_addr_a,
  input  logic [ADDR_W-1:0]          i_rd_addr_b,
  output logic signed [SAMPLE_W-1:0] o_rd_data_a,
  output logic signed [SAMPLE_W-1:0] o_rd_data_b
);

  logic signed [SAMPLE_W-1:0] r_mem [NUM_TAPS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < NUM_TAPS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_a = r_mem[i_rd_addr_a];
  assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Symmetric 32-tap FIR: each accepted sample is folded into 16 pair sums and
// accumulated through a single shared multiplier, then shifted and saturated.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 32,
  parameter int COEFF_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic signed [15:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              flush,
  output logic signed [15:0] filtered_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int MUL_W = PAIR_W + COEFF_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 37'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -37'sd32768;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > SAT_MAX)      r = 16'sh7fff;
    else if (v < SAT_MIN) r = 16'sh8000;
    else                  r = v[SAMPLE_W-1:0];
    return r;
  endfunction

  fir_state_t                 r_state, w_state_nxt;
  logic [ADDR_W-1:0]          r_wr_ptr;
  logic [ADDR_W-1:0]          r_p;
  logic [K_W-1:0]             r_k;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [SAMPLE_W-1:0] r_out;

  logic                       w_idle;
  logic                       w_accept;
  logic                       w_clear;
  logic [ADDR_W-1:0]          w_rd_a;
  logic [ADDR_W-1:0]          w_rd_b;
  logic signed [SAMPLE_W-1:0] w_x_a;
  logic signed [SAMPLE_W-1:0] w_x_b;
  logic signed [PAIR_W-1:0]   w_pair;
  logic signed [COEFF_W-1:0]  w_coeff;
  logic signed [MUL_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]    w_acc_shr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_clear  = w_idle && flush;
  assign w_accept = w_idle && !flush && sample_valid;

  // Newest sample walks backwards while its mirror partner walks forwards.
  assign w_rd_a = r_p - ADDR_W'(r_k);
  assign w_rd_b = r_p + ADDR_W'(1) + ADDR_W'(r_k);

  fir_delay_ram u_delay_ram (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_clear),
    .i_wr_en     (w_accept),
    .i_wr_addr   (r_wr_ptr),
    .i_wr_data   (sample_in),
    .i_rd_addr_a (w_rd_a),
    .i_rd_addr_b (w_rd_b),
    .o_rd_data_a (w_x_a),
    .o_rd_data_b (w_x_b)
  );

  assign w_pair    = PAIR_W'(w_x_a) + PAIR_W'(w_x_b);
  assign w_coeff   = coeff_at(r_k);
  assign w_prod    = MUL_W'(w_pair) * MUL_W'(w_coeff);
  assign w_acc_shr = r_acc >>> FRAC_W;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_MAC;
      ST_MAC:   if (r_k == K_W'(NUM_UNIQUE - 1)) w_state_nxt = ST_ROUND;
      ST_ROUND: w_state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_p      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_p      <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_acc    <= '0;
            r_k      <= '0;
          end else if (w_clear) begin
            r_wr_ptr <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_k   <= r_k + K_W'(1);
        end
        ST_ROUND: r_out <= sat16(w_acc_shr);
        default: ;
      endcase
    end
  end

  assign sample_ready = w_idle && !flush;
  assign out_valid    = (r_state == ST_OUT);
  assign busy         = !w_idle;
  assign filtered_out = r_out;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: impulse, DC, saturation, back-pressure,
// flush and mid-computation reset, against hand values and a direct-form model.
module tb_fir_mac_scheduler;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              flush = 1'b0;
  logic signed [15:0] filtered_out;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;

  always #5 clk = ~clk;

  fir_mac_scheduler #(.NUM_TAPS(32), .COEFF_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .flush        (flush),
    .filtered_out (filtered_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int last_lat = 0;
  int hist [32];
  int cf [16] = '{1, -3, 12, -28, 40, -13, -98, 279, -399, 213, 462, -1474, 2148, -1348, -2619, 19210};
  int imp_exp [16] = '{0, -2, 6, -14, 20, -7, -49, 139, -200, 106, 231, -737, 1074, -674, -1310, 9605};

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int h(input int j);
    return (j < 16) ? cf[j] : cf[31-j];
  endfunction

  function automatic int model_y();
    longint acc = 0;
    for (int j = 0; j < 32; j++) acc += longint'(h(j)) * longint'(hist[j]);
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic clear_hist();
    for (int j = 0; j < 32; j++) hist[j] = 0;
  endtask

  task automatic push(input int s);
    for (int j = 31; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = s;
  endtask

  // Called at a negedge; returns at the negedge after the output handshake
  // (or inside OUT when out_ready is low).
  task automatic do_sample(input int s, input string tag, output int y);
    int n;
    n = 0;
    while (!sample_ready && n < 200) begin @(negedge clk); n++; end
    if (!sample_ready) check({tag, "_ready_timeout"}, 0, 1);
    sample_in = 16'(s);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    push(s);
    n = 1;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    last_lat = n;
    if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
    y = filtered_out;
    check(tag, y, model_y());
    if (out_ready) @(negedge clk);
  endtask

  task automatic run_impulse(input int count, input string tag);
    int y;
    for (int j = 0; j < count; j++) begin
      do_sample((j == 0) ? 16384 : 0, tag, y);
      check({tag, "_hand"}, y, (j < 16) ? imp_exp[j] : imp_exp[31-j]);
      if (j == 0) check({tag, "_latency"}, last_lat, 18);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int y;
    int held;
    bit bad_v, bad_d, bad_r;
    int seen;
    clear_hist();

    repeat (3) @(negedge clk);
    check("rst_out", filtered_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", sample_ready, 1);

    run_impulse(32, "impulse");

    for (int i = 0; i < 40; i++) begin
      do_sample(32767, "dc_pos", y);
      if (i >= 31) check("dc_pos_hand", y, 32765);
    end
    for (int i = 0; i < 40; i++) begin
      do_sample(-32768, "dc_neg", y);
      if (i >= 31) check("dc_neg_hand", y, -32766);
    end

    for (int i = 0; i < 32; i++) begin
      do_sample((h(i) > 0) ? 32767 : -32767, "sat", y);
      if (i == 31) check("sat_hand", y, 32767);
    end

    out_ready = 1'b0;
    do_sample(1000, "stall_first", y);
    held = model_y();
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 50; i++) begin
      sample_in = 16'(7000 + i);
      sample_valid = (i % 5 == 0);
      @(negedge clk);
      if (out_valid !== 1'b1) bad_v = 1;
      if (filtered_out !== 16'(held)) bad_d = 1;
      if (sample_ready !== 1'b0) bad_r = 1;
    end
    sample_valid = 1'b0;
    check("stall_valid_held", bad_v, 0);
    check("stall_data_held", bad_d, 0);
    check("stall_ready_low", bad_r, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_hold", filtered_out, held);
    do_sample(-5000, "stall_after", y);

    flush = 1'b1;
    sample_valid = 1'b1;
    sample_in = 16'sd1234;
    #1;
    check("flush_ready", sample_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    sample_valid = 1'b0;
    check("flush_no_accept", busy, 0);
    clear_hist();
    run_impulse(32, "flush_imp");

    for (int i = 0; i < 10; i++) do_sample(20000, "pre_rst", y);
    sample_in = 16'sd30000;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", filtered_out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_hist();
    #1;
    check("mid_rel_ready", sample_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_no_valid", seen, 0);
    run_impulse(10, "post_rst_imp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
